// File: rtl/sqrt2_pkg.sv
// ---------------------------------------------------------------------------
// sqrt2_pkg -- shared definitions for the binary16 square-root block.
//   * binary16 field widths and exponent bias
//   * special-result encodings (negative quiet NaN, +inf, quiet-bit index)
//   * significand-root widths shared by sqrt2 and sqrt2_core
//   * FSM state type
// Build option: SQRT2_SUBNORMAL_EN (see sqrt2.sv) selects subnormal handling.
// ---------------------------------------------------------------------------
package sqrt2_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;

    localparam logic [15:0] QNAN_NEG  = 16'hFE00;
    localparam logic [15:0] PINF      = 16'h7C00;
    localparam int          QUIET_BIT = 9;

    // Significand radicand is m * 2^10 with m in [1,4): 12 bits.
    // Root is floor(sqrt(m) * 2^10): 11 bits (leading one + 10 fraction bits).
    localparam int RAD_W  = FRAC_W + 2;
    localparam int ROOT_W = FRAC_W + 1;

    // Counter value during the last CALC cycle (8th edge after capture).
    localparam logic [2:0] LAST_CYCLE = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/sqrt2_if.sv
// ---------------------------------------------------------------------------
// sqrt2_if -- control/data bundle between the sqrt2 controller and the
// iterative significand root engine.
//   start    : load radicand and clear the partial remainder/root
//   step     : perform one radix-4 iteration (two root bits)
//   radicand : 12-bit significand radicand
//   root     : 11-bit truncated root (valid after six steps)
// master = controller (sqrt2), slave = engine (sqrt2_core).
// ---------------------------------------------------------------------------
interface sqrt2_if;
    import sqrt2_pkg::*;

    logic              start;
    logic              step;
    logic [RAD_W-1:0]  radicand;
    logic [ROOT_W-1:0] root;

    modport master (output start, output step, output radicand, input root);
    modport slave  (input start, input step, input radicand, output root);

endinterface

// File: rtl/sqrt2_core.sv
// ---------------------------------------------------------------------------
// sqrt2_core -- radix-4 restoring integer square root of (radicand << 10).
// Two root bits are produced per step; six steps consume the 24-bit shifted
// radicand {2'b00, radicand, 10'b0} and leave floor(sqrt) in root.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sqrt2_if.slave (start, step, radicand in; root out)
// ---------------------------------------------------------------------------
module sqrt2_core
    import sqrt2_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    sqrt2_if.slave bus
);

    localparam int SH_W  = 2 * (ROOT_W + 1);
    // Remainder never exceeds 2*root, so ROOT_W+1 bits suffice.
    localparam int REM_W = ROOT_W + 1;

    typedef struct packed {
        logic [REM_W-1:0]  rem;
        logic [ROOT_W-1:0] root;
    } acc_t;

    logic [SH_W-1:0]   sh_q;
    logic [REM_W-1:0]  rem_q;
    logic [ROOT_W-1:0] root_q;
    acc_t              acc1;
    acc_t              acc2;

    // One radix-2 restoring step: bring down a bit pair, try (4*root + 1).
    function automatic acc_t iter(input acc_t a, input logic [1:0] pair);
        logic [REM_W+1:0] shifted;
        logic [REM_W+1:0] trial;
        acc_t             r;
        shifted = {a.rem, pair};
        trial   = {1'b0, a.root, 2'b01};
        if (shifted >= trial) begin
            r.rem  = REM_W'(shifted - trial);
            r.root = {a.root[ROOT_W-2:0], 1'b1};
        end else begin
            r.rem  = shifted[REM_W-1:0];
            r.root = {a.root[ROOT_W-2:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        acc1 = iter({rem_q, root_q}, sh_q[SH_W-1 -: 2]);
        acc2 = iter(acc1, sh_q[SH_W-3 -: 2]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the flops that synthesis builds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q   <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else if (bus.start) begin
            sh_q   <= {2'b00, bus.radicand, FRAC_W'(0)};
            rem_q  <= '0;
            root_q <= '0;
        end else if (bus.step) begin
            sh_q   <= sh_q << 4;
            rem_q  <= acc2.rem;
            root_q <= acc2.root;
        end
    end

    assign bus.root = root_q;

endmodule

// File: rtl/sqrt2.sv
// ---------------------------------------------------------------------------
// sqrt2 -- IEEE-754 binary16 square root, truncated, fixed 8-cycle latency.
// Ports:
//   CLK     : clock, rising edge
//   RST_N   : synchronous active-low reset
//   ENABLE  : high = start/hold operation, low = abort/finish
//   IO_DATA : bidirectional operand in (IDLE) / result out (DONE & ENABLE)
//   RESULT  : result valid, DUT driving IO_DATA
//   IS_NAN  : result is NaN
//   IS_PINF : result is +inf
//   IS_NINF : result is -inf (always 0)
// Build option: define SQRT2_SUBNORMAL_EN to normalise subnormal operands;
// otherwise subnormals flush to signed zero and no normaliser is built.
// ---------------------------------------------------------------------------
module sqrt2
    import sqrt2_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    inout  wire  [15:0] IO_DATA,
    output logic        RESULT,
    output logic        IS_NAN,
    output logic        IS_PINF,
    output logic        IS_NINF
);

    state_t             state;
    logic [2:0]         cnt;
    logic [15:0]        op_q;
    logic [15:0]        res_q;

    logic               sign_f;
    logic [EXP_W-1:0]   exp_f;
    logic [FRAC_W-1:0]  frac_f;

    logic [EXP_W:0]     t;       // biased exponent + BIAS, parity picks m or 2m
    logic [FRAC_W-1:0]  fnorm;
    logic [EXP_W-1:0]   res_exp;
    logic [15:0]        res_d;
    logic               nan_d;
    logic               pinf_d;

    sqrt2_if core_bus ();

    sqrt2_core u_core (
        .clk   (CLK),
        .rst_n (RST_N),
        .bus   (core_bus.slave)
    );

    assign sign_f = op_q[15];
    assign exp_f  = op_q[14 -: EXP_W];
    assign frac_f = op_q[FRAC_W-1:0];

`ifdef SQRT2_SUBNORMAL_EN
    // Leading zeros of a nonzero 10-bit fraction (highest set bit wins).
    function automatic logic [3:0] lzc10(input logic [FRAC_W-1:0] f);
        lzc10 = 4'd10;
        for (int i = 0; i < FRAC_W; i++) begin
            if (f[i]) lzc10 = 4'(FRAC_W - 1 - i);
        end
    endfunction

    logic [3:0] lz;
    assign lz = lzc10(frac_f);
`endif

    // Radicand preparation: result exponent is (exp + BIAS) >> 1; an odd sum
    // means an odd unbiased exponent, so the significand is doubled.
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        t     = {1'b0, exp_f} + (EXP_W+1)'(BIAS);
        fnorm = frac_f;
`ifdef SQRT2_SUBNORMAL_EN
        if (exp_f == '0) begin
            // Subnormal: shift the leading one into the hidden-bit position.
            t     = (EXP_W+1)'(BIAS) - {2'b00, lz};
            fnorm = frac_f << (lz + 4'd1);
        end
`endif
        core_bus.radicand = t[0] ? {1'b1, fnorm, 1'b0} : {2'b01, fnorm};
        res_exp           = t[EXP_W:1];
    end

    assign core_bus.start = (state == CALC) && (cnt == 3'd0);
    assign core_bus.step  = (state == CALC) && (cnt != 3'd0) && (cnt != LAST_CYCLE);

    // Result selection, specials first.
    always_comb begin
        res_d  = {1'b0, res_exp, core_bus.root[FRAC_W-1:0]};
        nan_d  = 1'b0;
        pinf_d = 1'b0;
        if (exp_f == '1 && frac_f != '0) begin
            res_d = op_q | (16'h0001 << QUIET_BIT);
            nan_d = 1'b1;
        end else if (exp_f == '0 && frac_f == '0) begin
            res_d = op_q;
`ifndef SQRT2_SUBNORMAL_EN
        end else if (exp_f == '0) begin
            res_d = {sign_f, 15'd0};
`endif
        end else if (sign_f) begin
            res_d = QNAN_NEG;
            nan_d = 1'b1;
        end else if (exp_f == '1) begin
            res_d  = PINF;
            pinf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            RESULT  <= 1'b0;
            IS_NAN  <= 1'b0;
            IS_PINF <= 1'b0;
        end else if (!ENABLE) begin
            state   <= IDLE;
            cnt     <= '0;
            res_q   <= '0;
            RESULT  <= 1'b0;
            IS_NAN  <= 1'b0;
            IS_PINF <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    op_q  <= IO_DATA;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST_CYCLE) begin
                        state   <= DONE;
                        res_q   <= res_d;
                        RESULT  <= 1'b1;
                        IS_NAN  <= nan_d;
                        IS_PINF <= pinf_d;
                    end
                end
                DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated directly by ENABLE so the bus is released as soon as it falls.
    assign IO_DATA = (state == DONE && ENABLE) ? res_q : 16'bz;
    assign IS_NINF = 1'b0;

endmodule

// File: tb/tb_sqrt2.sv
// ---------------------------------------------------------------------------
// tb_sqrt2 -- directed self-checking bench for sqrt2.
// Inputs change on the falling edge or 1 time unit after the rising edge;
// outputs are sampled 1 time unit after the rising edge.
// Bus release is observed by driving 0x0000 and then 0xFFFF from the bench:
// both must read back unaltered, which cannot happen while the DUT drives.
// ---------------------------------------------------------------------------
module tb_sqrt2;

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        logic        nan;
        logic        pinf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        tb_oe;
    logic [15:0] tb_val;
    wire  [15:0] io_data;
    logic        result;
    logic        is_nan;
    logic        is_pinf;
    logic        is_ninf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign io_data = tb_oe ? tb_val : 16'bz;

    sqrt2 dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .ENABLE  (enable),
        .IO_DATA (io_data),
        .RESULT  (result),
        .IS_NAN  (is_nan),
        .IS_PINF (is_pinf),
        .IS_NINF (is_ninf)
    );

    // Drives two complementary patterns; both read back only if the DUT is off the bus.
    task automatic probe_released(output logic released);
        logic [15:0] a;
        logic [15:0] b;
        tb_oe  = 1'b1;
        tb_val = 16'h0000;
        #1 a = io_data;
        tb_val = 16'hFFFF;
        #1 b = io_data;
        tb_oe = 1'b0;
        released = (a == 16'h0000) && (b == 16'hFFFF);
    endtask

    // Drives the operand over the capture edge and one more edge, then counts
    // edges after capture until RESULT (lat = 0 if it never rises in 20).
    task automatic run_op(input logic [15:0] op, output logic [15:0] res, output int lat);
        @(negedge clk);
        enable = 1'b1;
        tb_oe  = 1'b1;
        tb_val = op;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) tb_oe = 1'b0;
            if (result) begin
                lat = n;
                break;
            end
        end
        #1 res = io_data;
    endtask

    task automatic end_op;
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic rel;
        rst_n  = 1'b0;
        enable = 1'b0;
        tb_oe  = 1'b0;
        tb_val = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({result, is_nan, is_pinf, is_ninf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {result, is_nan, is_pinf, is_ninf});
        end
        probe_released(rel);
        checks++;
        if (rel !== 1'b1) begin
            errors++;
            $display("FAIL reset_bus_released: got %b expected 1", rel);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal;
        vec_t        v [3];
        logic [15:0] res;
        int          lat;
        v[0] = '{16'h1234, 16'h270B, 1'b0, 1'b0};
        v[1] = '{16'h6066, 16'h4DEE, 1'b0, 1'b0};
        v[2] = '{16'h10C7, 16'h262E, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(v[i].op, res, lat);
            checks++;
            if (res !== v[i].res) begin
                errors++;
                $display("FAIL normal_value op=%h: got %h expected %h", v[i].op, res, v[i].res);
            end
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL normal_latency op=%h: got %0d expected 8", v[i].op, lat);
            end
            checks++;
            if ({is_nan, is_pinf, is_ninf} !== 3'b000) begin
                errors++;
                $display("FAIL normal_flags op=%h: got %b expected 000", v[i].op, {is_nan, is_pinf, is_ninf});
            end
            end_op();
        end
    endtask

    task automatic test_subnormal;
        vec_t        v [3];
        int          n;
        logic [15:0] res;
        int          lat;
`ifdef SQRT2_SUBNORMAL_EN
        v[0] = '{16'h0016, 16'h14B0, 1'b0, 1'b0};
        v[1] = '{16'h002C, 16'h16A2, 1'b0, 1'b0};
        v[2] = '{16'h8016, 16'hFE00, 1'b1, 1'b0};
        n = 3;
`else
        v[0] = '{16'h0016, 16'h0000, 1'b0, 1'b0};
        v[1] = '{16'h8016, 16'h8000, 1'b0, 1'b0};
        v[2] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
        n = 2;
`endif
        for (int i = 0; i < n; i++) begin
            run_op(v[i].op, res, lat);
            checks++;
            if (res !== v[i].res) begin
                errors++;
                $display("FAIL subnormal_value op=%h: got %h expected %h", v[i].op, res, v[i].res);
            end
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL subnormal_latency op=%h: got %0d expected 8", v[i].op, lat);
            end
            checks++;
            if ({is_nan, is_pinf, is_ninf} !== {v[i].nan, v[i].pinf, 1'b0}) begin
                errors++;
                $display("FAIL subnormal_flags op=%h: got %b expected %b", v[i].op,
                         {is_nan, is_pinf, is_ninf}, {v[i].nan, v[i].pinf, 1'b0});
            end
            end_op();
        end
    endtask

    task automatic test_specials;
        vec_t        v [6];
        logic [15:0] res;
        int          lat;
        v[0] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
        v[1] = '{16'h8000, 16'h8000, 1'b0, 1'b0};
        v[2] = '{16'h7C00, 16'h7C00, 1'b0, 1'b1};
        v[3] = '{16'hFC00, 16'hFE00, 1'b1, 1'b0};
        v[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        v[5] = '{16'h7D00, 16'h7F00, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, res, lat);
            checks++;
            if (res !== v[i].res) begin
                errors++;
                $display("FAIL special_value op=%h: got %h expected %h", v[i].op, res, v[i].res);
            end
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL special_latency op=%h: got %0d expected 8", v[i].op, lat);
            end
            checks++;
            if ({is_nan, is_pinf, is_ninf} !== {v[i].nan, v[i].pinf, 1'b0}) begin
                errors++;
                $display("FAIL special_flags op=%h: got %b expected %b", v[i].op,
                         {is_nan, is_pinf, is_ninf}, {v[i].nan, v[i].pinf, 1'b0});
            end
            end_op();
        end
    endtask

    task automatic test_bus;
        logic rel;
        logic done_seen;
        @(negedge clk);
        enable = 1'b1;
        tb_oe  = 1'b1;
        tb_val = 16'h6066;
        @(posedge clk);
        #1;
        checks++;
        if (io_data !== 16'h6066) begin
            errors++;
            $display("FAIL bus_operand_capture: got %h expected 6066", io_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (io_data !== 16'h6066) begin
            errors++;
            $display("FAIL bus_operand_hold: got %h expected 6066", io_data);
        end
        tb_oe = 1'b0;
        @(posedge clk);
        #1;
        probe_released(rel);
        checks++;
        if (rel !== 1'b1 || result !== 1'b0) begin
            errors++;
            $display("FAIL bus_calc_released: got released=%b result=%b expected 1 0", rel, result);
        end
        done_seen = 1'b0;
        for (int n = 0; n < 20 && !done_seen; n++) begin
            @(posedge clk);
            #1;
            done_seen = result;
        end
        checks++;
        if (done_seen !== 1'b1 || io_data !== 16'h4DEE) begin
            errors++;
            $display("FAIL bus_done_drive: got result=%b data=%h expected 1 4dee", done_seen, io_data);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (result !== 1'b1 || io_data !== 16'h4DEE) begin
            errors++;
            $display("FAIL done_hold: got result=%b data=%h expected 1 4dee", result, io_data);
        end
        @(negedge clk);
        enable = 1'b0;
        probe_released(rel);
        checks++;
        if (rel !== 1'b1) begin
            errors++;
            $display("FAIL bus_release_on_enable_fall: got %b expected 1", rel);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({result, is_nan, is_pinf, is_ninf} !== 4'b0000) begin
            errors++;
            $display("FAIL finish_clear: got %b expected 0000", {result, is_nan, is_pinf, is_ninf});
        end
    endtask

    task automatic test_abort;
        logic        seen;
        logic [15:0] res;
        int          lat;
        @(negedge clk);
        enable = 1'b1;
        tb_oe  = 1'b1;
        tb_val = 16'h1234;
        @(posedge clk);
        @(posedge clk);
        #1 tb_oe = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 enable = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (result) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result: got %b expected 0", seen);
        end
        run_op(16'h6066, res, lat);
        checks++;
        if (res !== 16'h4DEE || lat !== 8) begin
            errors++;
            $display("FAIL abort_next_op: got %h lat=%0d expected 4dee lat=8", res, lat);
        end
        end_op();
    endtask

    task automatic test_reset_mid_calc;
        logic        rel;
        logic [15:0] res;
        int          lat;
        @(negedge clk);
        enable = 1'b1;
        tb_oe  = 1'b1;
        tb_val = 16'h10C7;
        @(posedge clk);
        @(posedge clk);
        #1 tb_oe = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({result, is_nan, is_pinf, is_ninf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_calc_outputs: got %b expected 0000", {result, is_nan, is_pinf, is_ninf});
        end
        probe_released(rel);
        checks++;
        if (rel !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_calc_bus: got %b expected 1", rel);
        end
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: got %b expected 0", result);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        run_op(16'h10C7, res, lat);
        checks++;
        if (res !== 16'h262E || lat !== 8) begin
            errors++;
            $display("FAIL reset_recovery: got %h lat=%0d expected 262e lat=8", res, lat);
        end
        end_op();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_normal();
        test_subnormal();
        test_specials();
        test_bus();
        test_abort();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqrt2.md
SQRT2 -- requirements
Module: sqrt2

Interface
Parameters: none.
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port ENABLE, input, 1 bit: operation request; high = start and hold the operation, low = abort or finish.
REQ-004 SHALL have port IO_DATA, inout, 16 bits: IEEE-754 binary16 operand in, result out.
REQ-005 SHALL have port RESULT, output, 1 bit: result valid, and the DUT is driving IO_DATA.
REQ-006 SHALL have port IS_NAN, output, 1 bit: result is NaN.
REQ-007 SHALL have port IS_PINF, output, 1 bit: result is +inf.
REQ-008 SHALL have port IS_NINF, output, 1 bit: result is -inf; constant 0, because sqrt never yields -inf.

Function
REQ-009 SHALL use states IDLE, CALC, DONE.
REQ-010 In IDLE, the first rising edge with ENABLE=1 SHALL capture IO_DATA and go to CALC.
REQ-011 Latency SHALL be fixed: RESULT rises on the 8th rising edge after the capture edge, which is also the CALC->DONE transition.
REQ-012 In DONE with ENABLE=1, the result and flags SHALL be held stable indefinitely.
REQ-013 ENABLE=0 in any state SHALL, at the next rising edge, go to IDLE and clear RESULT and all flags.
- An abort in CALC discards the computation.
- A new operation needs ENABLE low for at least one edge.
REQ-014 IO_DATA SHALL be driven only when state==DONE and ENABLE==1; otherwise high-Z.
- The drive enable is gated combinationally by ENABLE, so the bus is released the instant ENABLE falls.
REQ-015 Positive finite nonzero x SHALL produce round-toward-zero (truncated) sqrt(x) as a normal binary16.
- Method: unbiased exponent e, significand m in [1,2).
- If e is odd: m = 2m, e = e-1.
- Result exponent = e/2 + 15; result significand = floor of sqrt(m) to 10 fraction bits.
REQ-016 Positive subnormal inputs SHALL be normalised by leading-zero count before REQ-015 applies; a result is never subnormal, overflow or inexact-flagged.
REQ-017 Special cases SHALL be handled as follows:
- +0 -> 0x0000; -0 -> 0x8000.
- +inf -> 0x7C00, IS_PINF=1.
- Quiet NaN -> passed unchanged (e.g. 0xFFFF -> 0xFFFF).
- Signalling NaN -> quiet bit (bit 9) set, sign and payload kept (0x7D00 -> 0x7F00).
- Any negative nonzero non-NaN, including -inf and negative subnormals -> 0xFE00.
- IS_NAN=1 for every NaN result.
REQ-018 Flags SHALL be valid exactly when RESULT=1 and 0 otherwise.

Reset
REQ-019 With RST_N=0 at a rising edge, the block SHALL go to IDLE with:
- RESULT, IS_NAN, IS_PINF, IS_NINF = 0;
- IO_DATA high-Z;
- internal datapath registers cleared.
REQ-020 Reset SHALL take priority over ENABLE, including mid-CALC, where the computation is discarded.

Configuration
REQ-021 With macro SQRT2_SUBNORMAL_EN defined, subnormal inputs SHALL be handled per REQ-016.
REQ-022 Without SQRT2_SUBNORMAL_EN, subnormal inputs SHALL be flushed to signed zero.
- Positive subnormal -> 0x0000; negative subnormal -> 0x8000.
- Latency is unchanged.
- The leading-zero normaliser is not synthesised.

Structure
REQ-023 Package sqrt2_pkg SHALL hold:
- field widths (EXP_W=5, FRAC_W=10) and BIAS=15;
- constants QNAN_NEG=16'hFE00, PINF=16'h7C00, QUIET_BIT=9;
- the state enum type.
REQ-024 Sub-module sqrt2_core SHALL implement the iterative unsigned significand square root (radicand up to 12 bits, 11-bit truncated root).
- Radix-4: 2 bits per cycle within the CALC window.
- Classification, exponent logic and bus control live in sqrt2.

Verification
REQ-025 Bench SHALL cover 0x1234 -> 0x270B, 0x6066 -> 0x4DEE and 0x10C7 -> 0x262E.
- RESULT rises exactly 8 edges after capture.
- All flags 0.
REQ-026 Bench SHALL cover subnormals, with macro defined: 0x0016 -> 0x14B0 and 0x002C -> 0x16A2 (truncation, not nearest); without macro: 0x0016 -> 0x0000.
REQ-027 Bench SHALL cover specials:
- 0x0000 -> 0x0000; 0x8000 -> 0x8000.
- 0x7C00 -> 0x7C00 with IS_PINF=1.
- 0xFC00 -> 0xFE00 with IS_NAN=1.
- 0xFFFF -> 0xFFFF with IS_NAN=1.
- 0x7D00 -> 0x7F00 with IS_NAN=1.
REQ-028 Bench SHALL check bus protocol:
- IO_DATA is high-Z from the DUT before DONE and in the same timestep ENABLE falls.
- No contention while the bench drives the operand for 2 cycles.
REQ-029 Bench SHALL check aborts: ENABLE drops 3 edges after capture -> RESULT never asserts; the next operation (0x6066) returns 0x4DEE.
REQ-030 Bench SHALL check reset: RST_N=0 mid-CALC -> next edge IDLE, outputs 0, bus high-Z; the result is held while ENABLE stays high in DONE.
